// File: rtl/mmio_pkg.sv
// Shared MMIO definitions for the CPU's MEM-stage peripherals.
//   - Byte addresses of the LED, button and UART registers.
//   - Bit positions inside the UART status word.
//   - UART transmitter FSM state type and a status packing helper.
package mmio_pkg;

    localparam logic [31:0] LED_ADDR         = 32'h7A;
    localparam logic [31:0] BUTTON_ADDR      = 32'h7B;
    localparam logic [31:0] UART_DATA_ADDR   = 32'h7C;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h7D;

    // UART status word bit positions (bit 0 is always 0)
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_BUSY  = 3;
    localparam int ST_OVF   = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] pack_status(input logic empty,
                                                input logic full,
                                                input logic busy,
                                                input logic ovf);
        logic [31:0] s;
        s           = '0;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        s[ST_BUSY]  = busy;
        s[ST_OVF]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output.
//   clk, reset    : core clock, asynchronous active-low reset (flushes pointers)
//   push, din     : write request and data; accepted when not full, or when
//                   full but a pop happens on the same edge
//   pop           : remove the head; ignored when empty
//   dout          : current head entry (valid while !empty)
//   full, empty   : occupancy flags
//   count         : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter for the CPU's MEM-stage data port.
//   clk, reset   : core clock, asynchronous active-low reset
//   i_addr       : byte address of the access
//   i_wdata      : store data, bits [7:0] are the byte to send
//   i_mem_write  : one-cycle store strobe
//   i_mem_read   : load strobe
//   o_rdata      : registered load data (status word or 0)
//   o_hit        : registered; o_rdata answers last cycle's status load
//   o_uart_tx    : 8N1 serial line, idle high, driven from a flop
// Stores to DATA_ADDR queue a byte (dropped with a sticky overflow flag when
// the FIFO is full); loads from STATUS_ADDR return
// {overflow, busy, full, empty, 0} and clear the overflow flag.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 27_000_000,
    parameter int          BAUD        = 115200,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] DATA_ADDR   = UART_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR = UART_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_mem_write,
    input  logic        i_mem_read,
    output logic [31:0] o_rdata,
    output logic        o_hit,
    output logic        o_uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int FAW          = $clog2(FIFO_DEPTH);

    // ---------------- address decode ----------------
    logic wr_data, rd_status;
    assign wr_data   = i_mem_write && (i_addr == DATA_ADDR);
    assign rd_status = i_mem_read  && (i_addr == STATUS_ADDR);

    // ---------------- TX FIFO ----------------
    logic         fifo_pop, fifo_full, fifo_empty;
    logic [7:0]   fifo_dout;
    logic [FAW:0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (i_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Upper store bits and the occupancy count are not needed here.
    logic unused_ok;
    assign unused_ok = ^{i_wdata[31:8], fifo_count};

    // ---------------- transmitter FSM ----------------
    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic             busy;

    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign busy    = (state_q != TX_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // The line level is a registered copy of the current state's output, so
    // the line trails the state by one cycle and never glitches.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        fifo_pop  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = TX_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_uart_tx = tx_q;

    // ---------------- overflow flag and status read ----------------
    // A store lost to a full FIFO sets the flag; a status read clears it,
    // but a loss on that same edge must still be reported next time.
    logic ovf_q, ovf_set;
    assign ovf_set = wr_data && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q   <= 1'b0;
            o_hit   <= 1'b0;
            o_rdata <= '0;
        end else begin
            if (ovf_set)        ovf_q <= 1'b1;
            else if (rd_status) ovf_q <= 1'b0;
            o_hit   <= rd_status;
            o_rdata <= rd_status ? pack_status(fifo_empty, fifo_full, busy, ovf_q) : '0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
    import mmio_pkg::*;

    localparam int CPB   = 4;          // 16 Hz / 4 baud
    localparam int FRAME = 10 * CPB;   // start + 8 data + stop
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        i_mem_write = 1'b0;
    logic        i_mem_read = 1'b0;
    logic [31:0] o_rdata;
    logic        o_hit;
    logic        o_uart_tx;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference: the byte stream the line should carry, in order.
    byte unsigned exp_q[$];
    // Observed by the line receiver below.
    byte unsigned rx_q[$];
    int           rx_t[$];
    int           ferr = 0;

    mmio_uart_tx #(
        .CLK_FREQ_HZ (16),
        .BAUD        (4),
        .FIFO_DEPTH  (DEPTH),
        .DATA_ADDR   (32'h7C),
        .STATUS_ADDR (32'h7D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_mem_write (i_mem_write),
        .i_mem_read  (i_mem_read),
        .o_rdata     (o_rdata),
        .o_hit       (o_hit),
        .o_uart_tx   (o_uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 8N1 receiver: samples mid-bit on falling edges, drops frames cut by reset.
    logic [7:0] mon_b;
    bit         mon_ok, mon_good;
    int         mon_t0;
    initial forever begin
        @(negedge clk);
        if (reset && o_uart_tx === 1'b0) begin
            mon_t0 = cyc; mon_ok = 1'b1; mon_good = 1'b1; mon_b = '0;
            for (int k = 1; k <= 38; k++) begin
                @(negedge clk);
                if (!reset) mon_ok = 1'b0;
                if (k == 2 && o_uart_tx !== 1'b0) mon_good = 1'b0;
                if (k >= 6 && k <= 34 && (k % 4) == 2) mon_b[(k-6)/4] = o_uart_tx;
                if (k == 38 && o_uart_tx !== 1'b1) mon_good = 1'b0;
            end
            if (mon_ok) begin
                if (mon_good) begin
                    rx_q.push_back(mon_b);
                    rx_t.push_back(mon_t0);
                end else begin
                    ferr++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    int last_store;
    task automatic store(input logic [31:0] addr, input logic [7:0] data);
        i_addr = addr; i_wdata = {$urandom_range(0, 255), 16'h0, data} & 32'hFF0000FF;
        i_mem_write = 1'b1;
        tick();
        i_mem_write = 1'b0; i_addr = '0;
        last_store = cyc;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] rd, output logic hit);
        i_addr = addr; i_mem_read = 1'b1;
        tick();
        i_mem_read = 1'b0; i_addr = '0;
        rd = o_rdata; hit = o_hit;
    endtask

    logic [31:0] rd;
    logic        hit;

    task automatic status_is(input string tag, input logic [31:0] exp);
        load(32'h7D, rd, hit);
        chk({tag, ".hit"}, {31'b0, hit}, 32'd1);
        chk(tag, rd, exp);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin tick(); t++; end
        chk({tag, ".rx_count"}, rx_q.size(), n);
        repeat (4) tick();   // let the stop bit finish and the FSM return to idle
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, ".len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s.byte%0d", tag, i), rx_q[i], exp_q[i]);
        exp_q.delete(); rx_q.delete(); rx_t.delete();
    endtask

    task automatic reset_mid(input byte unsigned b, input int bitn);
        int ce, lows;
        store(32'h7C, b); ce = last_store;
        for (int i = 0; i < 3; i++) store(32'h7C, 8'($urandom));
        // line goes low at ce+2; data bit n spans ce+2+4*(n+1) .. +3
        while (cyc < ce + 2 + CPB * (bitn + 1) + 1) tick();
        chk($sformatf("rst_mid%0d.line_before", bitn), {31'b0, o_uart_tx}, {31'b0, b[bitn]});
        reset = 1'b0; #1;
        chk($sformatf("rst_mid%0d.line_async", bitn), {31'b0, o_uart_tx}, 32'd1);
        tick(); tick();
        chk($sformatf("rst_mid%0d.hit", bitn), {31'b0, o_hit}, 32'd0);
        reset = 1'b1; tick();
        status_is($sformatf("rst_mid%0d.status", bitn), 32'h02);
        lows = 0;
        for (int i = 0; i < 60; i++) begin tick(); if (o_uart_tx !== 1'b1) lows++; end
        chk($sformatf("rst_mid%0d.line_idle", bitn), lows, 0);
        chk($sformatf("rst_mid%0d.no_frame", bitn), rx_q.size(), 0);
        rx_q.delete(); rx_t.delete();
    endtask

    initial begin
        int ce, n, p1;
        byte unsigned v;

        // ---- reset state ----
        repeat (3) tick();
        chk("reset.line",  {31'b0, o_uart_tx}, 32'd1);
        chk("reset.hit",   {31'b0, o_hit},     32'd0);
        chk("reset.rdata", o_rdata,            32'd0);
        reset = 1'b1; tick();
        status_is("reset.status", 32'h02);

        // ---- single byte 0x55, latency and framing ----
        store(32'h7C, 8'h55); ce = last_store; exp_q.push_back(8'h55);
        wait_rx("t1", 1, 100);
        if (rx_t.size() > 0) chk("t1.latency", rx_t[0] - ce, 32'd2);
        compare_stream("t1");

        // ---- three back-to-back bytes ----
        store(32'h7C, 8'hA5); ce = last_store;
        store(32'h7C, 8'h3C);
        store(32'h7C, 8'hFF);
        exp_q = '{8'hA5, 8'h3C, 8'hFF};
        wait_rx("t2", 3, 250);
        if (rx_t.size() == 3) begin
            chk("t2.first", rx_t[0] - ce, 32'd2);
            chk("t2.gap1",  rx_t[1] - rx_t[0], FRAME + 1);
            chk("t2.gap2",  rx_t[2] - rx_t[1], FRAME + 1);
        end
        compare_stream("t2");
        status_is("t2.status", 32'h02);

        // ---- status hit, then foreign address ----
        load(32'h7D, rd, hit);
        chk("t4.hit", {31'b0, hit}, 32'd1);
        chk("t4.rdata", rd, 32'h02);
        load(32'h7B, rd, hit);
        chk("t4.miss_hit", {31'b0, hit}, 32'd0);
        chk("t4.miss_rdata", rd, 32'd0);
        load(32'h7C, rd, hit);
        chk("t4.data_load_hit", {31'b0, hit}, 32'd0);
        store(32'h7D, 8'h99);
        status_is("t4.status_store_ignored", 32'h02);

        // ---- overflow burst: 1 byte to the shifter + DEPTH queued, rest dropped ----
        n = $urandom_range(DEPTH + 2, DEPTH + 4);
        for (int i = 0; i < n; i++) begin
            v = 8'($urandom);
            store(32'h7C, v);
            if (i < DEPTH + 1) exp_q.push_back(v);
        end
        status_is("t3.status_ovf", 32'h1C);
        status_is("t3.status_clr", 32'h0C);
        wait_rx("t3", DEPTH + 1, (DEPTH + 1) * (FRAME + 1) + 60);
        compare_stream("t3");
        status_is("t3.status_end", 32'h02);

        // ---- store lands on the edge IDLE pops while full ----
        for (int i = 0; i < DEPTH + 1; i++) begin
            v = 8'($urandom);
            store(32'h7C, v);
            if (i == 0) ce = last_store;
            exp_q.push_back(v);
        end
        p1 = ce + 1 + FRAME + 1;     // second pop edge
        while (cyc < p1 - 1) tick();
        v = 8'($urandom);
        store(32'h7C, v); exp_q.push_back(v);
        status_is("t6.status", 32'h0C);
        wait_rx("t6", DEPTH + 2, (DEPTH + 2) * (FRAME + 1) + 60);
        compare_stream("t6");

        // ---- random bursts with random gaps ----
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                v = 8'($urandom);
                store(32'h7C, v); exp_q.push_back(v);
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_rx($sformatf("rnd%0d", r), n, n * (FRAME + 1) + 60);
            compare_stream($sformatf("rnd%0d", r));
        end
        status_is("rnd.status", 32'h02);

        // ---- reset mid-frame ----
        reset_mid(8'h0F, 3);
        reset_mid(8'h0F, 5);

        chk("frame_errors", ferr, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
